// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-requester round-robin arbiter with hold limit and forced release
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] idx_nxt;
    logic [7:0] hcnt, hcnt_nxt;
    logic       timeout_nxt;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       at_limit;
    logic       owner_req;

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign at_limit  = (hcnt == LIMIT);
    assign owner_req = req[gnt_idx];

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        hcnt_nxt    = hcnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = BUSY;
                    idx_nxt   = winner;
                    hcnt_nxt  = 8'd0;
                end
            end
            BUSY: begin
                if (done || !owner_req || at_limit) begin
                    state_nxt   = GAP;
                    ptr_nxt     = gnt_idx;
                    hcnt_nxt    = 8'd0;
                    // Only a pure hold-limit expiry counts as a forced release.
                    timeout_nxt = at_limit && !done && owner_req;
                end else begin
                    hcnt_nxt = hcnt + 8'd1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd3;
            gnt_idx <= 2'd0;
            hcnt    <= 8'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_idx <= idx_nxt;
            hcnt    <= hcnt_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign gnt_vld = (state == BUSY);
    assign gnt     = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 8, meaning the maximum number of cycles one grant is held before forced release (legal range 2..255).
REQ-002 SHALL provide clk  input  1  rising-edge clock; the block has only this one clock.
REQ-003 SHALL provide rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide req  input  4  per-requester request; bit i is requester i.
REQ-005 SHALL provide done  input  1  pulse from the current owner releasing the resource.
REQ-006 SHALL provide gnt  output  4  one-hot grant; decode of gnt_idx while gnt_vld=1, else 0000.
REQ-007 SHALL provide gnt_idx  output  2  binary index of the current or last owner.
REQ-008 SHALL provide gnt_vld  output  1  high while a grant is held.
REQ-009 SHALL provide timeout  output  1  single-cycle pulse on forced release.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and GAP, all registered.
REQ-011 IDLE: if req!=0 at a clock edge, SHALL select the winner, load gnt_idx, set gnt_vld=1 and enter BUSY at that edge; the grant is visible the cycle after req is sampled (latency 1).
REQ-012 IDLE with req=0 SHALL remain in IDLE with gnt=0000 and gnt_vld=0.
REQ-013 Winner selection SHALL be round-robin from last-owner pointer ptr: check order ptr+1, ptr+2, ptr+3, ptr (mod 4); first set bit wins.
REQ-014 ptr SHALL update to gnt_idx on every BUSY->GAP transition; index arithmetic SHALL wrap mod 4 (3+1=0).
REQ-015 BUSY: hold counter hcnt (8 bits) SHALL be 0 on entry and increment by 1 each BUSY cycle.
REQ-016 BUSY SHALL exit to GAP when done=1, when req[gnt_idx]=0, or when hcnt=MAX_HOLD-1, whichever occurs first.
REQ-017 timeout SHALL pulse for exactly the one cycle after a release caused only by hcnt=MAX_HOLD-1; if done=1 or req[gnt_idx]=0 in the same cycle, timeout SHALL stay 0.
REQ-018 A grant SHALL therefore last at most MAX_HOLD cycles.
REQ-019 GAP SHALL last exactly one cycle with gnt=0000 and gnt_vld=0, then go to IDLE; req changes during GAP are ignored until IDLE.
REQ-020 done asserted in IDLE or GAP SHALL be ignored.
REQ-021 gnt SHALL never have more than one bit set, and gnt_idx SHALL remain stable throughout BUSY.
REQ-022 A requester dropping and re-raising req within one BUSY grant SHALL not extend that grant; the drop releases it.
REQ-023 Requests in any state other than IDLE SHALL not be lost: a continuously held req is served in a later IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force state=IDLE, gnt=0000, gnt_idx=00, gnt_vld=0, timeout=0, hcnt=0 and ptr=3 (requester 0 has first priority).
REQ-025 Reset asserted mid-grant SHALL drop the grant asynchronously; after release the first arbitration SHALL follow REQ-013 with ptr=3.
REQ-026 Outputs SHALL remain at reset values until the first rising clk edge after rst_n returns to 1.

Verification
REQ-027 Bench SHALL run reset then req=0001 -> gnt=0001 and gnt_idx=00 one cycle later; done pulse -> next cycle gnt=0000 (GAP); then regrant 0001 if req held.
REQ-028 Bench SHALL hold req=1111, MAX_HOLD=8, done=0 -> grants in order 0001, 0010, 0100, 1000, 0001, each 8 cycles long, separated by one GAP cycle with timeout=1.
REQ-029 Bench SHALL set ptr=3 (last owner 3) with req=1001 -> gnt=0001; next arbitration with req=1001 -> gnt=1000 (wrap check).
REQ-030 Bench SHALL drive done=1 in the same cycle as hcnt=MAX_HOLD-1 -> release with timeout=0.
REQ-031 Bench SHALL pulse rst_n low mid-BUSY with gnt=0100 -> gnt=0000 without waiting for a clock; after release, req=0110 -> gnt=0010.
REQ-032 Bench SHALL check every cycle that gnt is 0000 or one-hot, gnt=decode(gnt_idx) when gnt_vld=1, and no BUSY period exceeds MAX_HOLD cycles.
